// File: rtl/bus_xfer_seq_pkg.sv
// Shared definitions for the bus transfer sequencer.
// Holds the source code map, the destination bit indices, the FSM state
// encodings and small decode helpers used by the sequencer.
package bus_xfer_seq_pkg;

  localparam int SRC_W   = 5;
  localparam int SRC_NUM = 24;

  // Source codes (index of the matching out-strobe bit)
  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R1     = 5'd1;
  localparam logic [4:0] SRC_R2     = 5'd2;
  localparam logic [4:0] SRC_R3     = 5'd3;
  localparam logic [4:0] SRC_R4     = 5'd4;
  localparam logic [4:0] SRC_R5     = 5'd5;
  localparam logic [4:0] SRC_R6     = 5'd6;
  localparam logic [4:0] SRC_R7     = 5'd7;
  localparam logic [4:0] SRC_R8     = 5'd8;
  localparam logic [4:0] SRC_R9     = 5'd9;
  localparam logic [4:0] SRC_R10    = 5'd10;
  localparam logic [4:0] SRC_R11    = 5'd11;
  localparam logic [4:0] SRC_R12    = 5'd12;
  localparam logic [4:0] SRC_R13    = 5'd13;
  localparam logic [4:0] SRC_R14    = 5'd14;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_LO     = 5'd16;
  localparam logic [4:0] SRC_HI     = 5'd17;
  localparam logic [4:0] SRC_ZLOW   = 5'd18;
  localparam logic [4:0] SRC_ZHIGH  = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_C      = 5'd23;
  localparam logic [4:0] SRC_LAST   = 5'd23;

  // Destination load-enable bit indices
  localparam int DST_R0IN      = 0;
  localparam int DST_R15IN     = 15;
  localparam int DST_LOIN      = 16;
  localparam int DST_HIIN      = 17;
  localparam int DST_YIN       = 18;
  localparam int DST_IRIN      = 19;
  localparam int DST_PCIN      = 20;
  localparam int DST_MDRIN     = 21;
  localparam int DST_MARIN     = 22;
  localparam int DST_OUTPORTIN = 23;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  function automatic logic src_is_legal(input logic [SRC_W-1:0] src);
    return (src <= SRC_LAST);
  endfunction

  // Illegal codes decode to all-zero so the bus is never driven by them.
  function automatic logic [SRC_NUM-1:0] src_decode(input logic [SRC_W-1:0] src);
    logic [SRC_NUM-1:0] oh;
    if (src <= SRC_LAST) begin
      oh = {{(SRC_NUM-1){1'b0}}, 1'b1} << src;
    end else begin
      oh = {SRC_NUM{1'b0}};
    end
    return oh;
  endfunction

endpackage

// File: rtl/bus_xfer_seq_fifo.sv
// bus_cmd_fifo: synchronous first-word-fall-through command FIFO.
// Ports: clk, clr (async active-low reset), push/pop requests, wdata in,
// rdata (head entry), full, empty, count (occupancy, AW+1 bits).
// A push while full is dropped even if a pop happens in the same cycle.
module bus_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 30
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == {(AW+1){1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      else         wr_ptr <= wr_ptr;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      else         rd_ptr <= rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: issues one-hot bus source strobes and destination load
// enables for queued register transfers, with a settle cycle (DRIVE) before
// every latch cycle and an optional wait for memory data.
// Ports: clk, clr (async active-low reset), cmd_valid/cmd_ready/cmd_src/
// cmd_dst/cmd_memwait command input, mem_ready, src_oh, dst_en, xfer_done,
// busy, err (sticky illegal source), err_clr.
module bus_xfer_seq
  import bus_xfer_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DST_W = 24
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [4:0]         cmd_src,
  input  logic [DST_W-1:0]   cmd_dst,
  input  logic               cmd_memwait,
  input  logic               mem_ready,
  output logic [23:0]        src_oh,
  output logic [DST_W-1:0]   dst_en,
  output logic               xfer_done,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = SRC_W + DST_W + 1;

  logic [FW-1:0]      fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic               pop;

  logic [SRC_W-1:0]   head_src;
  logic [DST_W-1:0]   head_dst;
  logic               head_memwait;

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic               load_hold;
  logic               set_err;
  logic [SRC_W-1:0]   hold_src;
  logic [DST_W-1:0]   hold_dst;
  logic               hold_memwait;

  bus_cmd_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata ({cmd_src, cmd_dst, cmd_memwait}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_src     = fifo_rdata[FW-1 -: SRC_W];
  assign head_dst     = fifo_rdata[DST_W:1];
  assign head_memwait = fifo_rdata[0];

  assign cmd_ready = ~fifo_full;
  assign busy      = (state != ST_IDLE) | (fifo_count != {(AW+1){1'b0}});

  // Next-state and pop decision; LATCH chains straight into the next DRIVE.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load_hold  = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE, ST_LATCH: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (src_is_legal(head_src)) begin
            load_hold  = 1'b1;
            next_state = ST_DRIVE;
          end else begin
            set_err    = 1'b1;
            next_state = ST_IDLE;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (hold_memwait && !mem_ready) next_state = ST_WAIT;
        else                            next_state = ST_LATCH;
      end
      ST_WAIT: begin
        if (mem_ready) next_state = ST_LATCH;
        else           next_state = ST_WAIT;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM state, holding register and sticky error flag (set wins over clear).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= ST_IDLE;
      hold_src     <= {SRC_W{1'b0}};
      hold_dst     <= {DST_W{1'b0}};
      hold_memwait <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= next_state;
      if (load_hold) begin
        hold_src     <= head_src;
        hold_dst     <= head_dst;
        hold_memwait <= head_memwait;
      end else begin
        hold_src     <= hold_src;
        hold_dst     <= hold_dst;
        hold_memwait <= hold_memwait;
      end
      if (set_err)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      else              err <= err;
    end
  end

  // Registered outputs decoded from the current state and holding register,
  // so strobes trail the state by one cycle and never glitch.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      src_oh    <= 24'h000000;
      dst_en    <= {DST_W{1'b0}};
      xfer_done <= 1'b0;
    end else begin
      if (state != ST_IDLE) src_oh <= src_decode(hold_src);
      else                  src_oh <= 24'h000000;
      if (state == ST_LATCH) begin
        dst_en    <= hold_dst;
        xfer_done <= 1'b1;
      end else begin
        dst_en    <= {DST_W{1'b0}};
        xfer_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed self-checking bench for bus_xfer_seq.
module tb_bus_xfer_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_src;
  logic [23:0] cmd_dst;
  logic        cmd_memwait;
  logic        mem_ready;
  logic [23:0] src_oh;
  logic [23:0] dst_en;
  logic        xfer_done;
  logic        busy;
  logic        err;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;

  bus_xfer_seq #(.DEPTH(4), .DST_W(24)) dut (
    .clk         (clk),
    .clr         (clr),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_memwait (cmd_memwait),
    .mem_ready   (mem_ready),
    .src_oh      (src_oh),
    .dst_en      (dst_en),
    .xfer_done   (xfer_done),
    .busy        (busy),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] s, input logic [23:0] d, input logic mw);
    cmd_valid   = 1'b1;
    cmd_src     = s;
    cmd_dst     = d;
    cmd_memwait = mw;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [23:0] s, input logic [23:0] d, input logic dn);
    chk({tag, ".src_oh"}, 32'(src_oh), 32'(s));
    chk({tag, ".dst_en"}, 32'(dst_en), 32'(d));
    chk({tag, ".xfer_done"}, 32'(xfer_done), 32'(dn));
  endtask

  logic [4:0]  bsrc [5];
  logic [23:0] bdst [5];

  initial begin
    bsrc = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd6};
    bdst = '{24'h000002, 24'h000004, 24'h000008, 24'h000020, 24'h000040};
    clr = 1'b0; cmd_valid = 1'b0; cmd_src = 5'd0; cmd_dst = 24'h0;
    cmd_memwait = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk_out("reset", 24'h0, 24'h0, 1'b0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.cmd_ready", 32'(cmd_ready), 32'h1);
    chk("reset.err", 32'(err), 32'h0);
    #11 clr = 1'b1;
    tick();

    // R4 -> R0
    push(5'd4, 24'h000001, 1'b0);
    chk("r4.busy_queued", 32'(busy), 32'h1);
    tick();
    chk_out("r4.pop", 24'h0, 24'h0, 1'b0);
    tick();
    chk_out("r4.drive", 24'h000010, 24'h0, 1'b0);
    tick();
    chk_out("r4.latch", 24'h000010, 24'h000001, 1'b1);
    chk("r4.busy_end", 32'(busy), 32'h0);
    tick();
    chk_out("r4.idle", 24'h0, 24'h0, 1'b0);

    // Back-to-back pushes; first command stalls on memwait to fill the FIFO
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_src = bsrc[i]; cmd_dst = bdst[i]; cmd_memwait = (i == 0);
      tick();
      chk($sformatf("b2b.ready%0d", i), 32'(cmd_ready), (i < 4) ? 32'h1 : 32'h0);
    end
    cmd_src = 5'd9; cmd_dst = 24'h800000; cmd_memwait = 1'b0;
    tick();
    chk("b2b.full_push_ignored", 32'(cmd_ready), 32'h0);
    chk("b2b.wait_src", 32'(src_oh), 32'h2);
    cmd_valid = 1'b0; mem_ready = 1'b1;
    tick();
    chk_out("b2b.wait_last", 24'h000002, 24'h0, 1'b0);
    tick();
    chk_out("b2b.latch0", 24'h000002, bdst[0], 1'b1);
    chk("b2b.ready_after_pop", 32'(cmd_ready), 32'h1);
    mem_ready = 1'b0;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk_out($sformatf("b2b.drive%0d", k), 24'h1 << bsrc[k], 24'h0, 1'b0);
      tick();
      chk_out($sformatf("b2b.latch%0d", k), 24'h1 << bsrc[k], bdst[k], 1'b1);
    end
    chk("b2b.busy_end", 32'(busy), 32'h0);
    tick();
    chk_out("b2b.idle", 24'h0, 24'h0, 1'b0);

    // MDR -> IR with memwait, mem_ready low for 3 cycles
    push(5'd21, 24'h080000, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("mw.hold%0d", k), 24'h200000, 24'h0, 1'b0);
    end
    mem_ready = 1'b1;
    tick();
    chk_out("mw.ready_seen", 24'h200000, 24'h0, 1'b0);
    mem_ready = 1'b0;
    tick();
    chk_out("mw.latch", 24'h200000, 24'h080000, 1'b1);
    tick();
    chk_out("mw.idle", 24'h0, 24'h0, 1'b0);

    // Illegal source 27 then PC -> MAR
    push(5'd27, 24'h000004, 1'b0);
    push(5'd20, 24'h400000, 1'b0);
    chk("ill.err_set", 32'(err), 32'h1);
    chk("ill.no_strobe", 32'(src_oh), 32'h0);
    tick();
    chk("ill.no_strobe2", 32'(src_oh), 32'h0);
    tick();
    chk_out("ill.pc_drive", 24'h100000, 24'h0, 1'b0);
    tick();
    chk_out("ill.pc_latch", 24'h100000, 24'h400000, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill.err_cleared", 32'(err), 32'h0);
    chk("ill.idle", 32'(src_oh), 32'h0);
    // set wins over a simultaneous clear
    push(5'd30, 24'h0, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill.set_wins", 32'(err), 32'h1);
    chk("ill.busy_after", 32'(busy), 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // C -> nothing (zero mask)
    push(5'd23, 24'h0, 1'b0);
    tick();
    tick();
    chk_out("zero.drive", 24'h800000, 24'h0, 1'b0);
    tick();
    chk_out("zero.latch", 24'h800000, 24'h0, 1'b1);
    tick();
    chk_out("zero.idle", 24'h0, 24'h0, 1'b0);

    // Reset in the middle of a LATCH cycle: MDR -> R3
    push(5'd21, 24'h000008, 1'b0);
    tick();
    tick();
    tick();
    chk_out("rst.latch", 24'h200000, 24'h000008, 1'b1);
    #2 clr = 1'b0;
    #1;
    chk_out("rst.async_drop", 24'h0, 24'h0, 1'b0);
    #1 clr = 1'b1;
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk_out("rst.after", 24'h0, 24'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_xfer_seq.md
Name: bus_xfer_seq

Overview:
- Sequencer on the control side of the shared 32-bit datapath bus: accepts queued register-transfer commands and issues the matching one-hot source out-strobes and destination load-enables.
- The source strobes feed the bus encoder/mux (R0out..Cout), and the destination enables feed the register load inputs (R0in..OutPortin).
- Guarantees at most one bus driver per cycle and a settle cycle before any destination latches.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- DST_W, 24, destination enable vector width

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_src  in  5  source code: 0-15 R0-R15, 16 LO, 17 HI, 18 Zlow, 19 Zhigh, 20 PC, 21 MDR, 22 InPort, 23 C; 24-31 illegal
- cmd_dst  in  DST_W  destination mask: 0-15 R0in-R15in, 16 LOin, 17 HIin, 18 Yin, 19 IRin, 20 PCin, 21 MDRin, 22 MARin, 23 OutPortin
- cmd_memwait  in  1  hold the transfer until mem_ready (MDR-sourced reads)
- mem_ready  in  1  memory data valid in MDR
- src_oh  out  24  one-hot out-strobes, bit n = source code n
- dst_en  out  DST_W  load enables
- xfer_done  out  1  one-cycle pulse in the latch cycle
- busy  out  1  FSM not IDLE or FIFO non-empty
- err  out  1  sticky illegal-source flag
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (clr=0, asynchronous):
  - FIFO emptied; FSM to IDLE.
  - src_oh=0, dst_en=0, xfer_done=0, err=0, busy=0, cmd_ready=1.
  - Reset mid-transfer abandons the transfer; outputs drop immediately, not at the next edge.
- Push: the FIFO accepts on cmd_valid & cmd_ready.
  - cmd_ready = !full.
  - Push while full is ignored, even if a pop occurs the same cycle.
  - Pointers wrap modulo DEPTH. An occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- FSM states: IDLE, DRIVE, WAIT, LATCH.
  - IDLE: if FIFO non-empty, pop the head into the holding register.
    - Legal source → DRIVE.
    - Source code ≥24 → set err, discard the command, stay IDLE, no strobes.
  - DRIVE: src_oh asserts the held source bit; dst_en=0 (bus settle cycle).
    - If memwait=1 and mem_ready=0 → WAIT.
    - Otherwise → LATCH.
  - WAIT: src_oh held, dst_en=0; → LATCH on the first cycle mem_ready=1.
  - LATCH: src_oh held, dst_en = held mask, xfer_done=1.
    - Next state is DRIVE with a new pop if the FIFO is non-empty and the head is legal.
    - An illegal head is handled as in IDLE: err set, head discarded, → IDLE.
    - Otherwise → IDLE.
- Latency and throughput:
  - Empty FIFO to first src_oh: 2 cycles after the push edge (push, pop/IDLE, DRIVE).
  - Steady-state throughput: one transfer per 2 cycles.
- Outputs are registered, decoded from FSM state and the holding register.
  - src_oh is always zero or one-hot.
  - dst_en is non-zero only in LATCH.
- A zero destination mask is legal: the bus is driven, no loads, and xfer_done still pulses.
- The memwait flag is honoured for any source, not only MDR.
- err: set on an illegal pop. err_clr clears it; set wins if both occur in the same cycle.
- busy = (state≠IDLE) | (count≠0).

Decomposition:
- Shared package holds:
  - source code constants SRC_R0..SRC_C and SRC_LAST=23
  - destination bit indices DST_R0IN..DST_OUTPORTIN
  - FSM state enum
- Natural sub-module: bus_cmd_fifo, a parameterised synchronous FIFO holding {src, dst, memwait} with push/pop/full/empty/count.

Test Plan:
- Reset mid-LATCH on a transfer from 21 (MDR) to dst bit 3: src_oh and dst_en drop to 0 asynchronously; after release, busy=0 and cmd_ready=1.
- Push {src=4, dst=0x000001} (R4 to R0): src_oh=0x000010 for 2 cycles; in the second cycle dst_en=0x000001 and xfer_done=1; then IDLE and busy=0.
- Push 5 back-to-back commands with DEPTH=4 while the FSM is busy: cmd_ready falls after 4 entries; all accepted commands emerge in order at 2-cycle spacing with no gap.
- Push {src=21, dst=bit19, memwait=1}, holding mem_ready low for 3 cycles: src_oh=bit21 throughout; dst_en stays 0 until the cycle after mem_ready rises; xfer_done pulses once.
- Push src=27 followed by a legal src=20: err=1, no strobe for the illegal command, the PC transfer proceeds normally; err_clr clears err.
- Push src=23 with dst=0: src_oh=bit23 for 2 cycles, dst_en stays 0, xfer_done pulses.
